// File: rtl/cu_pkg.sv
// Shared definitions for the control sequencer: IR field positions, opcodes, states and ALU strobe bits.
// CTRL_MULDIV_EN controls whether mul/div decode as a legal instruction class.
package cu_pkg;

    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int ALU_W    = 13;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_MUL  = 2;
    localparam int ALU_DIV  = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_OR   = 5;
    localparam int ALU_SHR  = 6;
    localparam int ALU_SHRA = 7;
    localparam int ALU_SHL  = 8;
    localparam int ALU_ROR  = 9;
    localparam int ALU_ROL  = 10;
    localparam int ALU_NEG  = 11;
    localparam int ALU_NOT  = 12;

    typedef enum logic [3:0] {
        RST,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU3,
        CLS_ALU2,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    // Groups opcodes by the shape of their execute sequence.
    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  cls = CLS_ALU3;
            OP_NEG, OP_NOT:                   cls = CLS_ALU2;
`ifdef CTRL_MULDIV_EN
            OP_MUL, OP_DIV:                   cls = CLS_MULDIV;
`endif
            OP_NOP:                           cls = CLS_NOP;
            OP_HALT:                          cls = CLS_HALT;
            default:                          cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    function automatic logic [ALU_W-1:0] alu_onehot(input logic [4:0] op);
        logic [ALU_W-1:0] v;
        v = '0;
        case (op)
            OP_ADD:  v[ALU_ADD]  = 1'b1;
            OP_SUB:  v[ALU_SUB]  = 1'b1;
            OP_MUL:  v[ALU_MUL]  = 1'b1;
            OP_DIV:  v[ALU_DIV]  = 1'b1;
            OP_AND:  v[ALU_AND]  = 1'b1;
            OP_OR:   v[ALU_OR]   = 1'b1;
            OP_SHR:  v[ALU_SHR]  = 1'b1;
            OP_SHRA: v[ALU_SHRA] = 1'b1;
            OP_SHL:  v[ALU_SHL]  = 1'b1;
            OP_ROR:  v[ALU_ROR]  = 1'b1;
            OP_ROL:  v[ALU_ROL]  = 1'b1;
            OP_NEG:  v[ALU_NEG]  = 1'b1;
            OP_NOT:  v[ALU_NOT]  = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cu_reg_select.sv
// Decodes a 4-bit register field into a one-hot register strobe, all-zero when not enabled.
module cu_reg_select
    import cu_pkg::*;
(
    input  logic [3:0]  field,
    input  logic        enable,
    output logic [15:0] onehot
);

    always_comb begin
        onehot = '0;
        if (enable) begin
            onehot[field] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch in T0-T2, opcode-specific execute in T3-T6, HALT until clear.
// Define CTRL_MULDIV_EN to enable mul/div sequences; otherwise they pulse illegal like unknown opcodes.
module control_sequencer
    import cu_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic [31:0]      ir,
    input  logic             mem_rdy,
    output logic             PCout,
    output logic             PCin,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             MDMuxread,
    output logic             IRin,
    output logic             Yin,
    output logic             Zlowin,
    output logic             Zhighin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIin,
    output logic             LOin,
    output logic             IncPC,
    output logic [15:0]      reg_in,
    output logic [15:0]      reg_out,
    output logic [ALU_W-1:0] alu_op,
    output logic             run,
    output logic             illegal
);

    state_t     state;
    state_t     state_next;
    op_class_t  op_class;
    logic [4:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic [3:0] out_field;
    logic       out_en;
    logic       in_en;
    logic       unused_ir_bits;

    assign op             = ir[OP_HI:OP_LO];
    assign ra             = ir[RA_HI:RA_LO];
    assign rb             = ir[RB_HI:RB_LO];
    assign rc             = ir[RC_HI:RC_LO];
    assign op_class       = classify(op);
    assign unused_ir_bits = ^ir[RC_LO-1:0];

    // T1 is the only state that can stall; everything else advances every clock.
    always_comb begin
        state_next = state;
        case (state)
            RST: state_next = T0;
            T0:  state_next = T1;
            T1:  state_next = mem_rdy ? T2 : T1;
            T2:  state_next = T3;
            T3: begin
                case (op_class)
                    CLS_ALU3, CLS_ALU2, CLS_MULDIV: state_next = T4;
                    CLS_HALT:                       state_next = HALT;
                    default:                        state_next = T0;
                endcase
            end
            T4:   state_next = (op_class == CLS_ALU3 || op_class == CLS_MULDIV) ? T5 : T0;
            T5:   state_next = (op_class == CLS_MULDIV) ? T6 : T0;
            T6:   state_next = T0;
            HALT: state_next = HALT;
            default: state_next = RST;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= RST;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        PCout     = 1'b0;
        PCin      = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        MDMuxread = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zlowin    = 1'b0;
        Zlowout   = 1'b0;
        IncPC     = 1'b0;
        alu_op    = '0;
        illegal   = 1'b0;
        out_field = rb;
        out_en    = 1'b0;
        in_en     = 1'b0;
        run       = (state != RST) && (state != HALT);
        case (state)
            T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            T1: begin
                Zlowout   = 1'b1;
                PCin      = 1'b1;
                MDMuxread = 1'b1;
                MDRin     = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                case (op_class)
                    CLS_ALU3: begin
                        out_en = 1'b1;
                        Yin    = 1'b1;
                    end
                    CLS_ALU2: begin
                        out_en = 1'b1;
                        alu_op = alu_onehot(op);
                        Zlowin = 1'b1;
                    end
                    CLS_MULDIV: begin
                        out_field = ra;
                        out_en    = 1'b1;
                        Yin       = 1'b1;
                    end
                    CLS_ILLEGAL: illegal = 1'b1;
                    default: ;
                endcase
            end
            T4: begin
                case (op_class)
                    CLS_ALU3: begin
                        out_field = rc;
                        out_en    = 1'b1;
                        alu_op    = alu_onehot(op);
                        Zlowin    = 1'b1;
                    end
                    CLS_ALU2: begin
                        Zlowout = 1'b1;
                        in_en   = 1'b1;
                    end
                    CLS_MULDIV: begin
                        out_en = 1'b1;
                        alu_op = alu_onehot(op);
                        Zlowin = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                if (op_class == CLS_ALU3) begin
                    Zlowout = 1'b1;
                    in_en   = 1'b1;
                end else if (op_class == CLS_MULDIV) begin
                    Zlowout = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // The 64-bit product/quotient path only exists when mul/div is built in.
`ifdef CTRL_MULDIV_EN
    assign Zhighin  = (state == T4) && (op_class == CLS_MULDIV);
    assign LOin     = (state == T5) && (op_class == CLS_MULDIV);
    assign Zhighout = (state == T6) && (op_class == CLS_MULDIV);
    assign HIin     = (state == T6) && (op_class == CLS_MULDIV);
`else
    assign Zhighin  = 1'b0;
    assign LOin     = 1'b0;
    assign Zhighout = 1'b0;
    assign HIin     = 1'b0;
`endif

    cu_reg_select u_sel_in (
        .field  (ra),
        .enable (in_en),
        .onehot (reg_in)
    );

    cu_reg_select u_sel_out (
        .field  (out_field),
        .enable (out_en),
        .onehot (reg_out)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction expected strobe traces, checked every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] ir = 32'h0;
    logic        mem_rdy = 1'b0;
    logic        PCout, PCin, MARin, MDRin, MDRout, MDMuxread, IRin, Yin;
    logic        Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, IncPC;
    logic [15:0] reg_in, reg_out;
    logic [12:0] alu_op;
    logic        run, illegal;

    control_sequencer dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_rdy(mem_rdy),
        .PCout(PCout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
        .MDMuxread(MDMuxread), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .IncPC(IncPC),
        .reg_in(reg_in), .reg_out(reg_out), .alu_op(alu_op), .run(run), .illegal(illegal)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        run;
        logic        illegal;
        logic [12:0] alu;
        logic [15:0] rin;
        logic [15:0] rout;
        logic pc_out, pc_in, mar_in, mdr_in, mdr_out, mdmux, ir_in, y_in;
        logic zlo_in, zhi_in, zlo_out, zhi_out, hi_in, lo_in, inc_pc;
    } outs_t;

    typedef struct packed {
        outs_t v;
        logic  rdy;
    } step_t;

    int     compared = 0;
    int     mismatched = 0;
    bit     exp_on = 1'b0;
    outs_t  exp_v = '0;
    outs_t  obs;
    step_t  plan[$];

    assign obs = {run, illegal, alu_op, reg_in, reg_out, PCout, PCin, MARin, MDRin, MDRout,
                  MDMuxread, IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, IncPC};

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (exp_on) checkOutput("cycle_trace", 64'(obs), 64'(exp_v));
    end

    function automatic outs_t blank(input logic r);
        outs_t o;
        o = '0;
        o.run = r;
        return o;
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] f);
        logic [15:0] x;
        x = '0;
        x[f] = 1'b1;
        return x;
    endfunction

    // Strobe bit for each ALU opcode, in the order ADD,SUB,MUL,DIV,AND,OR,SHR,SHRA,SHL,ROR,ROL,NEG,NOT.
    function automatic logic [12:0] alu_bit(input int op);
        int idx;
        case (op)
            3: idx = 0;   4: idx = 1;   15: idx = 2;  16: idx = 3;
            5: idx = 4;   6: idx = 5;   9: idx = 6;   10: idx = 7;
            11: idx = 8;  7: idx = 9;   8: idx = 10;  17: idx = 11;
            18: idx = 12; default: idx = -1;
        endcase
        return (idx < 0) ? 13'd0 : (13'd1 << idx);
    endfunction

    task automatic pushStep(input outs_t s, input logic r);
        step_t t;
        t.v = s;
        t.rdy = r;
        plan.push_back(t);
    endtask

    // Expected cycle-by-cycle trace of one instruction with w wait cycles in the memory read.
    task automatic buildPlan(input logic [31:0] instr, input int w, output bit halted, output bit has_t4);
        outs_t s;
        int op;
        logic [3:0] ra, rb, rc;
        bit muldiv_on;
`ifdef CTRL_MULDIV_EN
        muldiv_on = 1'b1;
`else
        muldiv_on = 1'b0;
`endif
        op = int'(instr[31:27]);
        ra = instr[26:23];
        rb = instr[22:19];
        rc = instr[18:15];
        halted = 1'b0;
        has_t4 = 1'b0;
        s = blank(1); s.pc_out = 1; s.mar_in = 1; s.inc_pc = 1; s.zlo_in = 1;
        pushStep(s, logic'($urandom_range(0, 1)));
        for (int i = 0; i <= w; i++) begin
            s = blank(1); s.zlo_out = 1; s.pc_in = 1; s.mdmux = 1; s.mdr_in = 1;
            pushStep(s, logic'(i == w));
        end
        s = blank(1); s.mdr_out = 1; s.ir_in = 1;
        pushStep(s, logic'($urandom_range(0, 1)));
        if (op >= 3 && op <= 11) begin
            has_t4 = 1'b1;
            s = blank(1); s.rout = oh(rb); s.y_in = 1;
            pushStep(s, logic'($urandom_range(0, 1)));
            s = blank(1); s.rout = oh(rc); s.alu = alu_bit(op); s.zlo_in = 1;
            pushStep(s, logic'($urandom_range(0, 1)));
            s = blank(1); s.zlo_out = 1; s.rin = oh(ra);
            pushStep(s, logic'($urandom_range(0, 1)));
        end else if (op == 17 || op == 18) begin
            has_t4 = 1'b1;
            s = blank(1); s.rout = oh(rb); s.alu = alu_bit(op); s.zlo_in = 1;
            pushStep(s, logic'($urandom_range(0, 1)));
            s = blank(1); s.zlo_out = 1; s.rin = oh(ra);
            pushStep(s, logic'($urandom_range(0, 1)));
        end else if ((op == 15 || op == 16) && muldiv_on) begin
            has_t4 = 1'b1;
            s = blank(1); s.rout = oh(ra); s.y_in = 1;
            pushStep(s, logic'($urandom_range(0, 1)));
            s = blank(1); s.rout = oh(rb); s.alu = alu_bit(op); s.zlo_in = 1; s.zhi_in = 1;
            pushStep(s, logic'($urandom_range(0, 1)));
            s = blank(1); s.zlo_out = 1; s.lo_in = 1;
            pushStep(s, logic'($urandom_range(0, 1)));
            s = blank(1); s.zhi_out = 1; s.hi_in = 1;
            pushStep(s, logic'($urandom_range(0, 1)));
        end else if (op == 26) begin
            pushStep(blank(1), logic'($urandom_range(0, 1)));
        end else if (op == 27) begin
            halted = 1'b1;
            pushStep(blank(1), logic'($urandom_range(0, 1)));
            for (int i = 0; i < 10; i++) pushStep(blank(0), logic'($urandom_range(0, 1)));
        end else begin
            s = blank(1); s.illegal = 1;
            pushStep(s, logic'($urandom_range(0, 1)));
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic releaseReset();
        repeat (2) @(posedge clock);
        #3;
        clear = 1'b1;
        tick();
    endtask

    task automatic applyReset();
        exp_v = '0;
        clear = 1'b0;
        #2;
        checkOutput("reset_all_zero", 64'(obs), 64'd0);
        releaseReset();
    endtask

    // Plays the queued trace; entered one step after the edge that starts T0.
    task automatic applyStimulus(input int abort_idx);
        for (int k = 0; k < plan.size(); k++) begin
            exp_v = plan[k].v;
            mem_rdy = plan[k].rdy;
            if (k == abort_idx) begin
                #1;
                clear = 1'b0;
                exp_v = '0;
                #1;
                checkOutput("abort_outputs_zero", 64'(obs), 64'd0);
                releaseReset();
                break;
            end
            tick();
        end
        plan.delete();
    endtask

    task automatic directedFetch(input logic [31:0] instr, input int waits);
        ir = instr;
        mem_rdy = (waits == 0);
        checkOutput("fetch_T0", 64'({PCout, MARin, IncPC, Zlowin, run}), 64'h1F);
        tick();
        for (int i = 0; i <= waits; i++) begin
            mem_rdy = (i == waits);
            checkOutput("fetch_T1_hold", 64'({PCin, MDRin, Zlowout, MDMuxread}), 64'hF);
            tick();
        end
        checkOutput("fetch_T2", 64'({MDRout, IRin, PCin}), 64'h6);
        tick();
    endtask

    initial begin
        bit halted, has_t4;
        int sel, op, w;
        logic [31:0] rnd, instr;
        int legal_ops[15] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18, 26, 26};

        #1;
        applyReset();

        directedFetch(32'h93380000, 0);
        checkOutput("not_T3_reg_out", 64'(reg_out), 64'h0080);
        checkOutput("not_T3_alu_zlowin", 64'({alu_op, Zlowin, Yin}), 64'({13'h1000, 1'b1, 1'b0}));
        tick();
        checkOutput("not_T4_zlowout_reg_in", 64'({Zlowout, reg_in, reg_out}), 64'({1'b1, 16'h0040, 16'h0}));
        tick();
        checkOutput("not_back_to_T0", 64'({PCout, run}), 64'h3);

        directedFetch(32'h18918000, 3);
        checkOutput("add_T3", 64'({reg_out, Yin}), 64'({16'h0004, 1'b1}));
        tick();
        checkOutput("add_T4", 64'({reg_out, alu_op, Zlowin}), 64'({16'h0008, 13'h0001, 1'b1}));
        tick();
        checkOutput("add_T5", 64'({Zlowout, reg_in}), 64'({1'b1, 16'h0002}));
        tick();
        checkOutput("add_back_to_T0", 64'(PCout), 64'h1);

        directedFetch(32'h7A280000, 0);
`ifdef CTRL_MULDIV_EN
        checkOutput("mul_T3", 64'({reg_out, Yin, illegal}), 64'({16'h0010, 1'b1, 1'b0}));
        tick();
        checkOutput("mul_T4", 64'({reg_out, alu_op, Zlowin, Zhighin}), 64'({16'h0020, 13'h0004, 2'b11}));
        tick();
        checkOutput("mul_T5", 64'({Zlowout, LOin, HIin}), 64'h6);
        tick();
        checkOutput("mul_T6", 64'({Zhighout, HIin, LOin}), 64'h6);
        tick();
`else
        checkOutput("mul_illegal_T3", 64'({illegal, reg_out, Yin, alu_op}), 64'({1'b1, 16'h0, 1'b0, 13'h0}));
        tick();
`endif
        checkOutput("mul_back_to_T0", 64'({PCout, illegal}), 64'h2);

        directedFetch(32'hD8000000, 0);
        checkOutput("halt_T3", 64'(obs), 64'({1'b1, 61'h0}));
        tick();
        for (int i = 0; i < 10; i++) begin
            checkOutput("halt_idle", 64'(obs), 64'd0);
            tick();
        end
        applyReset();
        checkOutput("after_halt_T0", 64'({PCout, run}), 64'h3);

        exp_on = 1'b1;
        ir = 32'h18918000;
        buildPlan(ir, 0, halted, has_t4);
        applyStimulus(4);

        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 4) op = 27;
            else if (sel < 16) op = $urandom_range(0, 31);
            else op = legal_ops[$urandom_range(0, 14)];
            rnd = $urandom();
            instr = {op[4:0], rnd[26:0]};
            w = $urandom_range(0, 3);
            ir = instr;
            buildPlan(instr, w, halted, has_t4);
            if (has_t4 && $urandom_range(0, 9) == 0) applyStimulus(w + 4);
            else applyStimulus(-1);
            if (halted) applyReset();
        end
        exp_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have: clear  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: ir  in  32  IR contents; op=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15].
REQ-004 SHALL have: mem_rdy  in  1  memory read data valid on Mdatain.
REQ-005 SHALL have outputs, each 1 bit: PCout, PCin, MARin, MDRin, MDRout, MDMuxread, IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, IncPC; each directly drives the datapath strobe of the same name.
REQ-006 SHALL have: reg_in  out  16  one-hot R0in..R15in.
REQ-007 SHALL have: reg_out  out  16  one-hot R0out..R15out.
REQ-008 SHALL have: alu_op  out  13  one-hot ADD,SUB,MUL,DIV,AND,OR,SHR,SHRA,SHL,ROR,ROL,NEG,NOT (bit 0 = ADD).
REQ-009 SHALL have: run  out  1  high while executing; illegal  out  1  one-cycle pulse on an undecodable opcode.

Function
REQ-010 SHALL be a Moore FSM; outputs decoded from state register plus ir fields only; at most one reg_in bit and one reg_out bit high.
REQ-011 States SHALL be RST, T0..T6, HALT; each T-state lasts one clock except T1.
REQ-012 T0 SHALL assert PCout, MARin, IncPC, Zlowin; next T1.
REQ-013 T1 SHALL assert Zlowout, PCin, MDMuxread, MDRin every cycle; stays in T1 while mem_rdy=0; goes to T2 on the edge where mem_rdy=1.
REQ-014 T2 SHALL assert MDRout, IRin; next T3.
REQ-015 ALU 3-reg ops (op 00011..01011: add,sub,and,or,ror,rol,shr,shra,shl): T3 reg_out[rb], Yin; T4 reg_out[rc], alu_op, Zlowin; T5 Zlowout, reg_in[ra]; next T0.
REQ-016 neg (10001), not (10010): T3 reg_out[rb], alu_op, Zlowin; T4 Zlowout, reg_in[ra]; next T0.
REQ-017 mul (01111), div (10000): T3 reg_out[ra], Yin; T4 reg_out[rb], alu_op, Zlowin, Zhighin; T5 Zlowout, LOin; T6 Zhighout, HIin; next T0.
REQ-018 nop (11010) SHALL go T3->T0 with no strobes in T3.
REQ-019 halt (11011) SHALL go T3->HALT; HALT holds, all strobes 0, run=0, until clear.
REQ-020 Any other opcode SHALL pulse illegal in T3, no other strobes, next T0.
REQ-021 run SHALL be 1 in T0..T6, 0 in RST and HALT.

Reset
REQ-022 clear=0 SHALL force state RST immediately, regardless of current state; all outputs 0, reg_in=reg_out=0, alu_op=0.
REQ-023 First rising clock with clear=1 SHALL move RST->T0.

Configuration
REQ-024 Macro CTRL_MULDIV_EN: defined -> REQ-017 sequences; undefined -> mul/div handled per REQ-020 (illegal pulse), T5/T6 unreachable, HIin/LOin/Zhighin/Zhighout tied 0.

Structure
REQ-025 Package cu_pkg SHALL hold opcode constants, state enum, alu_op bit indices, IR field positions.
REQ-026 Sub-module cu_reg_select SHALL decode a 4-bit field plus enable to a 16-bit one-hot.

Verification
REQ-027 Reset, ir=0x93380000 (not R6,R7), mem_rdy=1 -> T0..T4 then T0; T3 reg_out=0x0080, alu_op NOT, Zlowin; T4 Zlowout, reg_in=0x0040.
REQ-028 mem_rdy=0 for 3 cycles in T1 -> T1 held 4 cycles with PCin/MDRin high throughout, then T2.
REQ-029 ir=0x18918000 (add R1,R2,R3) -> T3 reg_out=0x0004,Yin; T4 reg_out=0x0008, ADD, Zlowin; T5 Zlowout, reg_in=0x0002.
REQ-030 ir=0x7A280000 (mul R4,R5) -> with CTRL_MULDIV_EN: T4 Zlowin+Zhighin, T5 LOin, T6 HIin; without: illegal one cycle in T3, then T0.
REQ-031 ir=0xD8000000 (halt) -> HALT, run=0 for 10 cycles; clear low -> RST; release -> T0.
REQ-032 clear driven low mid-T4 between edges -> all outputs 0 within same cycle, no further strobes until release.
